// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared FSM encoding, stall lengths and forwarding select codes
package hazard_stall_unit_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hsu_state_e;

  localparam logic [1:0] STALL_LOAD_USE = 2'd1;
  localparam logic [1:0] STALL_BR_ALU   = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD  = 2'd2;

  // Kept here so the forwarding unit and this block agree on operand source codes
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_WB    = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - wrapping event counter, cleared by reset
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch-operand stall and flush control
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs1,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] ID_EX_RegisterRd,
  input  logic              EX_MEM_MemRead,
  input  logic [REG_AW-1:0] EX_MEM_RegisterRd,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  hsu_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need_n;
  logic       hit_idex, hit_exmem;
  logic       stall_raw, stall;

  function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              use_rs);
    return use_rs && (rd != '0) && (rd == rs);
  endfunction

  assign hit_idex  = reg_match(ID_EX_RegisterRd, IF_ID_RegisterRs1, id_uses_rs1) |
                     reg_match(ID_EX_RegisterRd, IF_ID_RegisterRs2, id_uses_rs2);
  assign hit_exmem = reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRs1, id_uses_rs1) |
                     reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRs2, id_uses_rs2);

  always_comb begin
    need_n = 2'd0;
    if (id_is_branch) begin
      if (ID_EX_MemRead && hit_idex)
        need_n = STALL_BR_LOAD;
      else if ((ID_EX_RegWrite && hit_idex) || (EX_MEM_MemRead && hit_exmem))
        need_n = STALL_BR_ALU;
    end else if (ID_EX_MemRead && hit_idex) begin
      need_n = STALL_LOAD_USE;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (need_n != 2'd0) begin
          stall_raw = 1'b1;
          if (need_n > 2'd1) begin
            state_d = ST_HOLD;
            cnt_d   = need_n - 2'd1;
          end
        end
      end
      ST_HOLD: begin
        stall_raw = 1'b1;
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must release the pipeline even while hazard inputs are still asserted
  assign stall          = rst_n & stall_raw;
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign id_ex_bubble   = stall;
  assign if_id_flush    = rst_n & id_branch_taken & ~stall;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .count (stall_cycles)
  );

  hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, idex_rd = '0, exmem_rd = '0;
  logic        u1 = 0, u2 = 0, br = 0, tk = 0, idex_mr = 0, idex_rw = 0, exmem_mr = 0;
  logic        pc_we, ifid_we, bubble, flush;
  logic [31:0] stall_cycles, flush_count;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] tally_s = 0, tally_f = 0;

  hazard_stall_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IF_ID_RegisterRs1 (rs1),
    .IF_ID_RegisterRs2 (rs2),
    .id_uses_rs1       (u1),
    .id_uses_rs2       (u2),
    .id_is_branch      (br),
    .id_branch_taken   (tk),
    .ID_EX_MemRead     (idex_mr),
    .ID_EX_RegWrite    (idex_rw),
    .ID_EX_RegisterRd  (idex_rd),
    .EX_MEM_MemRead    (exmem_mr),
    .EX_MEM_RegisterRd (exmem_rd),
    .pc_write_en       (pc_we),
    .if_id_write_en    (ifid_we),
    .id_ex_bubble      (bubble),
    .if_id_flush       (flush),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " pc_we"},   {31'd0, pc_we},   {31'd0, ~e.stall});
      check({e.name, " ifid_we"}, {31'd0, ifid_we}, {31'd0, ~e.stall});
      check({e.name, " bubble"},  {31'd0, bubble},  {31'd0, e.stall});
      check({e.name, " flush"},   {31'd0, flush},   {31'd0, e.flush});
      check({e.name, " stall_cycles"}, stall_cycles, e.sc);
      check({e.name, " flush_count"},  flush_count,  e.fc);
    end
  end

  // One cycle: apply inputs just after the edge, queue what that cycle must show
  task automatic step(input string nm, input bit rst,
                      input logic [4:0] a_rs1, input logic [4:0] a_rs2, input bit a_u1, input bit a_u2,
                      input bit a_br, input bit a_tk, input bit a_imr, input bit a_irw,
                      input logic [4:0] a_ird, input bit a_emr, input logic [4:0] a_erd,
                      input bit e_stall, input bit e_flush);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2; br = a_br; tk = a_tk;
    idex_mr = a_imr; idex_rw = a_irw; idex_rd = a_ird; exmem_mr = a_emr; exmem_rd = a_erd;
    if (!rst) begin
      tally_s = 0;
      tally_f = 0;
    end
    e.name  = nm;
    e.stall = e_stall;
    e.flush = e_flush;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = tally_s;
    e.fc = tally_f;
`else
    e.sc = 0;
    e.fc = 0;
`endif
    exp_q.push_back(e);
    if (rst) begin
      tally_s = tally_s + {31'd0, e_stall};
      tally_f = tally_f + {31'd0, e_flush};
    end
  endtask

  task automatic quiet(input string nm);
    step(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    //   name            rst rs1 rs2 u1 u2 br tk imr irw ird emr erd  stall flush
    step("reset_hz",      0,  5,  0, 1, 0, 0, 1, 1,  1,  5,  0,  0,   0,    0);
    quiet("idle");
    // load-use, one bubble
    step("lu_stall",      1,  5,  0, 1, 0, 0, 0, 1,  1,  5,  0,  0,   1,    0);
    step("lu_release",    1,  5,  0, 1, 0, 0, 0, 0,  0,  0,  0,  5,   0,    0);
    // load feeding branch: two cycles, taken during hold is suppressed
    step("brld_run",      1,  0,  6, 0, 1, 1, 1, 1,  1,  6,  0,  0,   1,    0);
    step("brld_hold",     1,  0,  6, 0, 1, 1, 1, 0,  0,  0,  1,  6,   1,    0);
    step("brld_flush",    1,  0,  6, 0, 1, 1, 1, 0,  0,  0,  0,  0,   0,    1);
    quiet("idle2");
    // ALU result feeding branch
    step("bralu_stall",   1,  7,  0, 1, 0, 1, 0, 0,  1,  7,  0,  0,   1,    0);
    step("bralu_rd0",     1,  0,  0, 1, 0, 1, 0, 0,  1,  0,  0,  0,   0,    0);
    step("bralu_nouse",   1,  7,  0, 0, 0, 1, 1, 0,  1,  7,  0,  0,   0,    1);
    step("alu_nobranch",  1,  7,  0, 1, 0, 0, 0, 0,  1,  7,  0,  0,   0,    0);
    step("br_exmem_ld",   1,  9,  0, 1, 0, 1, 0, 0,  0,  0,  1,  9,   1,    0);
    step("ld_x0",         1,  0,  0, 1, 1, 0, 0, 1,  1,  0,  0,  0,   0,    0);
    // back-to-back: second hazard evaluated on the first RUN cycle
    step("b2b_run1",      1,  0,  3, 0, 1, 1, 0, 1,  1,  3,  0,  0,   1,    0);
    step("b2b_hold1",     1,  0,  3, 0, 1, 1, 0, 0,  0,  0,  1,  3,   1,    0);
    step("b2b_lu",        1,  4,  0, 1, 0, 0, 0, 1,  1,  4,  0,  0,   1,    0);
    quiet("idle3");
    // reset while in HOLD
    step("rst_run",       1,  0,  8, 0, 1, 1, 1, 1,  1,  8,  0,  0,   1,    0);
    step("rst_hold",      0,  0,  8, 0, 1, 1, 1, 0,  0,  0,  1,  8,   0,    0);
    step("rst_after",     1,  0,  0, 0, 0, 0, 1, 0,  0,  0,  0,  0,   0,    1);
    step("post_rst_lu",   1,  2,  0, 1, 0, 0, 0, 1,  1,  2,  0,  0,   1,    0);
    quiet("post_rst_rel");
    quiet("final");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: pending %0d required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
